pc_fetch_unit: RTL and testbench

Owns the architectural PC and fetches instructions for the single-issue RV32 core over a valid/ready instruction-memory port. It presents {pc, instruction} to decode/execute and the next-PC calculator. It takes the next-PC value and the unknown-instruction flag back from that stage on retire. It halts on an unknown instruction, a misaligned target or a bus error.

---
 rtl/pc_fetch_unit_pkg.sv | 36 +++
 rtl/pc_fetch_unit.sv | 179 +++++++++++++++++
 tb/tb_pc_fetch_unit.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit_pkg
// Shared definitions for the RV32 PC / instruction fetch unit:
//   - fetch_state_e : fetch FSM encoding (BOOT, FETCH, WAIT, ISSUE, HALT)
//   - XLEN          : architectural width (only 32 is supported)
//   - RESET_PC_DEFAULT, NOP_INST : reset values
//   - is_misaligned, count_inc   : small helpers used by the fetch FSM
// -----------------------------------------------------------------------------
package pc_fetch_unit_pkg;

  localparam int unsigned XLEN = 32'd32;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

  // addi x0, x0, 0 -- what io_instruction shows before the first fetch lands
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [2:0] {
    ST_BOOT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ISSUE = 3'd3,
    ST_HALT  = 3'd4
  } fetch_state_e;

  // Without compressed instructions every target must be word aligned
  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

  // Modulo-2^32 counter step; wraps 0xFFFF_FFFF -> 0 by construction
  function automatic logic [31:0] count_inc(input logic [31:0] value);
    return value + 32'd1;
  endfunction

endpackage

// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
// Owns the architectural PC of the single-issue RV32 core. Fetches one
// instruction at a time over a valid/ready instruction-memory port, presents
// {io_pc_count, io_instruction} downstream and, on retire, takes pc_next and
// is_unknown_instruction back from the next-PC calculator. Halts permanently
// (until reset) on an unknown instruction, a misaligned target or a bus error.
//
// Ports
//   clock, reset            : rising-edge clock, asynchronous active-low reset
//   imem_req_valid/ready    : fetch request handshake
//   imem_req_addr           : fetch address (always the current PC)
//   imem_resp_valid/data/err: fetch response, only honoured while waiting
//   inst_valid/inst_ready   : downstream issue / retire handshake
//   io_pc_count             : current PC
//   io_instruction          : latched instruction word
//   pc_next                 : next PC, taken verbatim on retire
//   is_unknown_instruction  : decode verdict, sampled on retire
//   halted, fault, fault_pc : sticky stop status and offending address
//   retire_count            : retired instruction count (wraps)
//
// RETIRE_COUNT_INIT is the reset value of retire_count. The core uses 0;
// a non-zero value only exists so the wrap of the counter can be exercised
// without billions of retires.
// -----------------------------------------------------------------------------
module pc_fetch_unit #(
  parameter int unsigned     XLEN              = 32'd32,
  parameter logic [XLEN-1:0] RESET_PC          = pc_fetch_unit_pkg::RESET_PC_DEFAULT,
  parameter logic [XLEN-1:0] RETIRE_COUNT_INIT = {XLEN{1'b0}}
) (
  input  logic            clock,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            imem_resp_err,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] io_pc_count,
  output logic [XLEN-1:0] io_instruction,
  input  logic [XLEN-1:0] pc_next,
  input  logic            is_unknown_instruction,
  output logic            halted,
  output logic            fault,
  output logic [XLEN-1:0] fault_pc,
  output logic [XLEN-1:0] retire_count
);

  import pc_fetch_unit_pkg::*;

  fetch_state_e    state_r;
  fetch_state_e    state_s;
  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] pc_s;
  logic [XLEN-1:0] instr_r;
  logic [XLEN-1:0] instr_s;
  logic [XLEN-1:0] retire_r;
  logic [XLEN-1:0] retire_s;
  logic [XLEN-1:0] fault_pc_r;
  logic [XLEN-1:0] fault_pc_s;
  logic            fault_r;
  logic            fault_s;
  logic            halted_r;
  logic            req_valid_r;
  logic            inst_valid_r;

  // Next-state and next-datapath decode for the fetch FSM
  always_comb begin
    state_s    = state_r;
    pc_s       = pc_r;
    instr_s    = instr_r;
    retire_s   = retire_r;
    fault_s    = fault_r;
    fault_pc_s = fault_pc_r;

    case (state_r)
      ST_BOOT: begin
        // One idle cycle after reset release before the first request
        state_s = ST_FETCH;
      end

      ST_FETCH: begin
        // Request stays up with a stable address until it is accepted
        if (imem_req_ready) begin
          state_s = ST_WAIT;
        end else begin
          state_s = ST_FETCH;
        end
      end

      ST_WAIT: begin
        if (imem_resp_valid) begin
          if (imem_resp_err) begin
            // Bus error: keep the previous instruction, record the PC
            state_s    = ST_HALT;
            fault_s    = 1'b1;
            fault_pc_s = pc_r;
          end else begin
            state_s = ST_ISSUE;
            instr_s = imem_resp_data;
          end
        end else begin
          state_s = ST_WAIT;
        end
      end

      ST_ISSUE: begin
        if (inst_ready) begin
          if (is_unknown_instruction) begin
            // Not retired: pc and retire_count keep their values
            state_s = ST_HALT;
          end else if (is_misaligned(pc_next)) begin
            // The instruction itself retired; only its target is illegal
            state_s    = ST_HALT;
            fault_s    = 1'b1;
            fault_pc_s = pc_next;
            retire_s   = count_inc(retire_r);
          end else begin
            state_s  = ST_FETCH;
            pc_s     = pc_next;
            retire_s = count_inc(retire_r);
          end
        end else begin
          state_s = ST_ISSUE;
        end
      end

      ST_HALT: begin
        state_s = ST_HALT;
      end

      default: begin
        // Corrupted state encoding: stop the core and flag it as a fault
        state_s    = ST_HALT;
        fault_s    = 1'b1;
        fault_pc_s = pc_r;
      end
    endcase
  end

  // State, datapath and registered handshake/status outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_BOOT;
      pc_r         <= RESET_PC;
      instr_r      <= NOP_INST;
      retire_r     <= RETIRE_COUNT_INIT;
      fault_pc_r   <= {XLEN{1'b0}};
      fault_r      <= 1'b0;
      halted_r     <= 1'b0;
      req_valid_r  <= 1'b0;
      inst_valid_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      pc_r         <= pc_s;
      instr_r      <= instr_s;
      retire_r     <= retire_s;
      fault_pc_r   <= fault_pc_s;
      fault_r      <= fault_s;
      // Decoding from the next state makes these flops track state_r exactly
      halted_r     <= (state_s == ST_HALT);
      req_valid_r  <= (state_s == ST_FETCH);
      inst_valid_r <= (state_s == ST_ISSUE);
    end
  end

  assign imem_req_valid = req_valid_r;
  assign imem_req_addr  = pc_r;
  assign inst_valid     = inst_valid_r;
  assign io_pc_count    = pc_r;
  assign io_instruction = instr_r;
  assign halted         = halted_r;
  assign fault          = fault_r;
  assign fault_pc       = fault_pc_r;
  assign retire_count   = retire_r;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_unit
// Directed bench for pc_fetch_unit. Stimulus pushes expected request
// addresses, expected retire contents and expected status snapshots into
// queues; a negedge monitor pops and compares whenever the DUT presents a
// request handshake, a retire handshake or a pending snapshot. A second
// instance with retire_count preset to 0xFFFF_FFFF shares all inputs so the
// counter wrap is visible after a single retire.
// -----------------------------------------------------------------------------
module tb_pc_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clock;
  logic        reset;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        imem_resp_err;
  logic        inst_ready;
  logic [31:0] pc_next;
  logic        is_unknown_instruction;

  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        inst_valid;
  logic [31:0] io_pc_count;
  logic [31:0] io_instruction;
  logic        halted;
  logic        fault;
  logic [31:0] fault_pc;
  logic [31:0] retire_count;

  logic        w_req_valid;
  logic [31:0] w_req_addr;
  logic        w_inst_valid;
  logic [31:0] w_pc;
  logic [31:0] w_instr;
  logic        w_halted;
  logic        w_fault;
  logic [31:0] w_fault_pc;
  logic [31:0] w_retire;

  pc_fetch_unit dut (
    .clock(clock), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .imem_resp_err(imem_resp_err),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .io_pc_count(io_pc_count), .io_instruction(io_instruction),
    .pc_next(pc_next), .is_unknown_instruction(is_unknown_instruction),
    .halted(halted), .fault(fault), .fault_pc(fault_pc),
    .retire_count(retire_count)
  );

  pc_fetch_unit #(.RETIRE_COUNT_INIT(32'hFFFF_FFFF)) dut_w (
    .clock(clock), .reset(reset),
    .imem_req_valid(w_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(w_req_addr), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .imem_resp_err(imem_resp_err),
    .inst_valid(w_inst_valid), .inst_ready(inst_ready),
    .io_pc_count(w_pc), .io_instruction(w_instr),
    .pc_next(pc_next), .is_unknown_instruction(is_unknown_instruction),
    .halted(w_halted), .fault(w_fault), .fault_pc(w_fault_pc),
    .retire_count(w_retire)
  );

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] retire;
    logic [31:0] fpc;
    logic        h;
    logic        f;
    logic        rv;
    logic        iv;
  } snap_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] retire;
  } iss_t;

  logic [31:0] req_q[$];
  iss_t        iss_q[$];
  snap_t       probe_q[$];

  int   checks = 0;
  int   errors = 0;
  logic done   = 1'b0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endfunction

  function automatic snap_t mk(input string n, input logic [31:0] pc,
                               input logic [31:0] instr, input logic [31:0] retire,
                               input logic [31:0] fpc, input logic h, input logic f,
                               input logic rv, input logic iv);
    snap_t s;
    s.name = n; s.pc = pc; s.instr = instr; s.retire = retire; s.fpc = fpc;
    s.h = h; s.f = f; s.rv = rv; s.iv = iv;
    return s;
  endfunction

  // Monitor: all comparisons happen here, on the falling edge
  always @(negedge clock) begin
    logic [31:0] a;
    iss_t        e;
    snap_t       p;
    if (imem_req_valid && imem_req_ready) begin
      if (req_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL req_unexpected: got request at %h want none", imem_req_addr);
      end else begin
        a = req_q.pop_front();
        chk("req_addr", imem_req_addr, a);
      end
    end
    if (inst_valid && inst_ready) begin
      if (iss_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL retire_unexpected: got retire of pc %h want none", io_pc_count);
      end else begin
        e = iss_q.pop_front();
        chk("retire_pc", io_pc_count, e.pc);
        chk("retire_instr", io_instruction, e.instr);
        chk("retire_count_at_retire", retire_count, e.retire);
      end
    end
    if (probe_q.size() != 0) begin
      p = probe_q.pop_front();
      chk({p.name, ".pc"}, io_pc_count, p.pc);
      chk({p.name, ".req_addr"}, imem_req_addr, p.pc);
      chk({p.name, ".instr"}, io_instruction, p.instr);
      chk({p.name, ".retire_count"}, retire_count, p.retire);
      chk({p.name, ".fault_pc"}, fault_pc, p.fpc);
      chk({p.name, ".halted"}, {31'd0, halted}, {31'd0, p.h});
      chk({p.name, ".fault"}, {31'd0, fault}, {31'd0, p.f});
      chk({p.name, ".req_valid"}, {31'd0, imem_req_valid}, {31'd0, p.rv});
      chk({p.name, ".inst_valid"}, {31'd0, inst_valid}, {31'd0, p.iv});
      chk({p.name, ".wrap_retire"}, w_retire, p.retire + 32'hFFFF_FFFF);
    end
    if (done) begin
      chk("req_q_left", req_q.size(), 32'd0);
      chk("iss_q_left", iss_q.size(), 32'd0);
      chk("probe_q_left", probe_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic probe(input snap_t s);
    probe_q.push_back(s);
    tick();
  endtask

  // Zero-wait fetch: accept this cycle, respond the next
  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data,
                          input logic err);
    req_q.push_back(addr);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = data;
    imem_resp_err   = err;
    tick();
    imem_resp_valid = 1'b0;
    imem_resp_err   = 1'b0;
    imem_resp_data  = 32'h0;
  endtask

  task automatic do_retire(input logic [31:0] pc, input logic [31:0] instr,
                           input logic [31:0] retire, input logic [31:0] nxt,
                           input logic unk);
    iss_t e;
    e.pc = pc; e.instr = instr; e.retire = retire;
    iss_q.push_back(e);
    inst_ready             = 1'b1;
    pc_next                = nxt;
    is_unknown_instruction = unk;
    tick();
    inst_ready             = 1'b0;
    is_unknown_instruction = 1'b0;
  endtask

  // Reset, check reset values, release, check the idle BOOT cycle
  task automatic reset_boot();
    reset = 1'b0;
    tick();
    tick();
    probe(mk("reset", RST_PC, NOP, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    reset = 1'b1;
    probe(mk("boot", RST_PC, NOP, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0));
  endtask

  initial begin
    logic [31:0] data_tab [0:4];
    logic [31:0] pc;
    data_tab[0] = NOP;
    data_tab[1] = 32'h0010_0093;
    data_tab[2] = 32'h0020_0113;
    data_tab[3] = 32'h0030_0193;
    data_tab[4] = 32'h0040_0213;

    reset                  = 1'b0;
    imem_req_ready         = 1'b0;
    imem_resp_valid        = 1'b0;
    imem_resp_data         = 32'h0;
    imem_resp_err          = 1'b0;
    inst_ready             = 1'b0;
    pc_next                = 32'h0;
    is_unknown_instruction = 1'b0;

    // First fetch after reset release
    reset_boot();
    do_fetch(RST_PC, NOP, 1'b0);
    probe(mk("issue0", RST_PC, NOP, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1));
    do_retire(RST_PC, NOP, 32'd0, 32'h8000_0004, 1'b0);
    probe(mk("req1", 32'h8000_0004, NOP, 32'd1, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0));

    // Back-to-back instructions at 3 cycles each
    for (int i = 1; i <= 4; i++) begin
      pc = RST_PC + 32'(4 * i);
      do_fetch(pc, data_tab[i], 1'b0);
      do_retire(pc, data_tab[i], 32'(i), pc + 32'd4, 1'b0);
    end
    probe(mk("after5", 32'h8000_0014, 32'h0040_0213, 32'd5, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0));

    // Request held 4 cycles, then issue held 6 cycles with a stray response
    for (int k = 0; k < 4; k++) begin
      probe(mk("fetch_stall", 32'h8000_0014, 32'h0040_0213, 32'd5, 32'd0,
               1'b0, 1'b0, 1'b1, 1'b0));
    end
    do_fetch(32'h8000_0014, 32'h00A0_0513, 1'b0);
    for (int k = 0; k < 6; k++) begin
      imem_resp_valid = (k == 2);
      imem_resp_data  = (k == 2) ? 32'hDEAD_BEEF : 32'h0;
      probe(mk("issue_stall", 32'h8000_0014, 32'h00A0_0513, 32'd5, 32'd0,
               1'b0, 1'b0, 1'b0, 1'b1));
    end
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    do_retire(32'h8000_0014, 32'h00A0_0513, 32'd5, 32'h8000_0018, 1'b0);

    // Unknown instruction: halt without fault, then everything is ignored
    do_fetch(32'h8000_0018, 32'hFFFF_FFFF, 1'b0);
    do_retire(32'h8000_0018, 32'hFFFF_FFFF, 32'd6, 32'h8000_0010, 1'b1);
    for (int k = 0; k < 3; k++) begin
      imem_req_ready  = 1'b1;
      imem_resp_valid = 1'b1;
      inst_ready      = 1'b1;
      pc_next         = 32'h8000_0020;
      probe(mk("halt_unknown", 32'h8000_0018, 32'hFFFF_FFFF, 32'd6, 32'd0,
               1'b1, 1'b0, 1'b0, 1'b0));
    end
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    inst_ready      = 1'b0;

    // Reset during WAIT; the stale response lands in BOOT and is dropped
    reset_boot();
    req_q.push_back(RST_PC);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    reset = 1'b0;
    tick();
    reset           = 1'b1;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h1234_5678;
    probe(mk("boot_stale", RST_PC, NOP, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    probe(mk("fetch_after_stale", RST_PC, NOP, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0));
    do_fetch(RST_PC, NOP, 1'b0);
    do_retire(RST_PC, NOP, 32'd0, 32'h8000_0004, 1'b0);
    probe(mk("wrap", 32'h8000_0004, NOP, 32'd1, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0));

    // Misaligned target: retired, faulted, pc not updated
    reset_boot();
    do_fetch(RST_PC, NOP, 1'b0);
    do_retire(RST_PC, NOP, 32'd0, 32'h8000_0102, 1'b0);
    probe(mk("misaligned", RST_PC, NOP, 32'd1, 32'h8000_0102, 1'b1, 1'b1, 1'b0, 1'b0));

    // Bus error on the fetch at 0x8000_0008
    reset_boot();
    do_fetch(RST_PC, NOP, 1'b0);
    do_retire(RST_PC, NOP, 32'd0, 32'h8000_0008, 1'b0);
    do_fetch(32'h8000_0008, 32'h0000_0073, 1'b1);
    probe(mk("bus_error", 32'h8000_0008, NOP, 32'd1, 32'h8000_0008, 1'b1, 1'b1, 1'b0, 1'b0));

    done = 1'b1;
    repeat (4) tick();
  end

endmodule
